fsk_bit_decoder: RTL and testbench
==================================

# fsk_bit_decoder

Downstream consumer of the two-tone frequency analyzer. Over each bit window it samples the analyzer's accumulated tone-1 and tone-2 tick counts and decides space, mark or error. It then pulses the analyzer's clear for the next window and assembles decided bits LSB-first into words. Words are handed to the capture-control logic through a valid/ready handshake.

## Interface
- `CLOCK`, 50000000: system clock frequency, Hz.
- `BIT_RATE`, 1000: bits per second; `WINDOW_TICKS = CLOCK / BIT_RATE`, must be ≥ 4 (elaboration error otherwise).
- `MIN_OCCUPANCY`, 50: percent of the window the dominant tone must cover; `THRESHOLD = WINDOW_TICKS * MIN_OCCUPANCY / 100`.
- `DATA_WIDTH`, 8: bits per assembled word.

Ports:
- `clock`  in  1  system clock.
- `clear`  in  1  reset; synchronous, active-high.
- `enable`  in  1  decoder runs when high.
- `f1_value`  in  32  analyzer tone-1 tick accumulation, unsigned.
- `f2_value`  in  32  analyzer tone-2 tick accumulation, unsigned.
- `analyzer_clear`  out  1  clear strobe to the analyzer.
- `bit_valid`  out  1  one-cycle strobe; a new decision is on `bit_value`/`bit_error`.
- `bit_value`  out  1  0 = space (tone 1), 1 = mark (tone 2).
- `bit_error`  out  1  decision was ambiguous.
- `word_data`  out  DATA_WIDTH  assembled word, LSB = first bit received.
- `word_valid`  out  1  `word_data` is valid; held until accepted.
- `word_ready`  in  1  consumer accepts on a cycle where `word_valid & word_ready`.
- `overrun`  out  1  sticky; a completed word was dropped.

## Operation
- Window counter `wc`, 0..WINDOW_TICKS-1, increments on each enabled cycle and wraps.
- Capture edge E is the edge where `wc == WINDOW_TICKS-1` and `enable` is high:
  - `wc` returns to 0.
  - `f1_value` and `f2_value` are latched into `f1_q` and `f2_q`.
  - `analyzer_clear` is registered to 1.
- Decision, applied at E+1 and computed from `f1_q`/`f2_q` with 32-bit unsigned compares:
  - SPACE: `f1_q >= THRESHOLD` and `f1_q > f2_q`.
  - MARK: `f2_q >= THRESHOLD` and `f2_q > f1_q`.
  - ERROR: any other case, including a tie, or neither tone reaching threshold.
- Outputs at E+1: `bit_valid` = 1 for exactly one cycle; `bit_value` = 1 only for MARK; `bit_error` = 1 only for ERROR. `bit_value` and `bit_error` hold until the next decision.
- Word assembly:
  - A SPACE or MARK bit shifts into position `cnt`, and `cnt` increments.
  - An ERROR bit discards the partial word and sets `cnt` to 0.
  - When `cnt` reaches DATA_WIDTH, the word completes and `cnt` returns to 0.
- Word completion at E+1:
  - If `word_valid == 0`, or `word_ready == 1` on that same cycle: load `word_data` and set `word_valid` = 1.
  - Otherwise: drop the new word, keep the old one, and set `overrun` = 1.
- Handshake:
  - `word_valid` falls on the edge after a `word_valid & word_ready` cycle, unless a new word loads on that same edge.
  - `word_data` is stable while `word_valid` is high.
- `enable` low: `wc`, `cnt`, the shift register and the word outputs hold; no capture occurs; `bit_valid` and `analyzer_clear` are 0. The partial window resumes when `enable` returns high.

## Timing
- Reset values (while `clear` is high, including mid-window or mid-word):
  - `analyzer_clear` = 1.
  - `wc` = 0, `cnt` = 0.
  - `bit_valid`, `bit_value`, `bit_error`, `word_valid`, `overrun` = 0; `word_data` = 0.
- After reset release:
  - `analyzer_clear` is 0 from the first edge after `clear` falls.
  - The first capture occurs WINDOW_TICKS enabled cycles later.
- Latency:
  - Capture edge to `bit_valid`: 1 cycle.
  - The last bit of a word and its `word_valid` appear on the same edge.
- `analyzer_clear` is high for exactly one cycle per window: the cycle after E, coinciding with `wc == 0`.
- Decision throughput is one bit per WINDOW_TICKS cycles. No back-pressure on bits; only words are back-pressured.

## Structure
- Package `fsk_pkg` holds:
  - The `WINDOW_TICKS` and `THRESHOLD` computation functions.
  - Decision enum `DEC_SPACE`, `DEC_MARK`, `DEC_ERROR`.
  - Constant `TICK_WIDTH = 32`.
- Sub-module `fsk_word_assembler` holds the shift register, `cnt`, the word output register, the handshake and overrun logic; its input is the decision strobe.
- The top level holds the window counter, capture registers and decision logic.

## Test plan
All scenarios use CLOCK=100000, BIT_RATE=1000 (WINDOW_TICKS=100), MIN_OCCUPANCY=50 (THRESHOLD=50), DATA_WIDTH=8.
- Reset: `clear` high for 3 cycles → `analyzer_clear` = 1 and all other outputs 0; one cycle after release `analyzer_clear` = 0; the first `analyzer_clear` pulse arrives 100 cycles later.
- Space bit: `f1`=70, `f2`=10 at capture → at E+1 `bit_valid` = 1 for one cycle, `bit_value` = 0, `bit_error` = 0.
- Error bit: `f1`=20, `f2`=30 after three good bits → `bit_error` = 1; the next eight good bits form a complete word, with no leftover bits.
- Word: bits 1,0,1,1,0,0,1,0 → `word_data` = 0x4D with `word_valid` = 1 on the eighth `bit_valid`; held for 5 cycles with `word_ready` low; drops on the edge after `word_ready` = 1.
- Overrun: a second word completes while the first is unaccepted → `overrun` = 1 and `word_data` stays 0x4D. A repeat run with `word_ready` = 1 on the completion cycle → new word loaded, `overrun` stays 0.
- Enable gap: `enable` low for 30 cycles mid-window → capture and `analyzer_clear` occur at cycle 130 instead of 100, with no `bit_valid` during the gap.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared constants, decision encoding and window/threshold helpers for the FSK bit decoder.
package fsk_pkg;

  localparam int TICK_WIDTH = 32;

  typedef enum logic [1:0] {
    DEC_SPACE = 2'd0,
    DEC_MARK  = 2'd1,
    DEC_ERROR = 2'd2
  } dec_e;

  function automatic int calc_window_ticks(input longint clock_hz, input longint bit_rate);
    longint ticks;
    ticks = clock_hz / bit_rate;
    return int'(ticks);
  endfunction

  function automatic int calc_threshold(input int window_ticks, input int min_occupancy);
    longint prod;
    prod = longint'(window_ticks) * longint'(min_occupancy);
    return int'(prod / 100);
  endfunction

  // Ties and sub-threshold windows fall through to ERROR.
  function automatic dec_e decide(input logic [TICK_WIDTH-1:0] f1,
                                  input logic [TICK_WIDTH-1:0] f2,
                                  input logic [TICK_WIDTH-1:0] thr);
    dec_e res;
    res = DEC_ERROR;
    if ((f1 >= thr) && (f1 > f2)) begin
      res = DEC_SPACE;
    end else if ((f2 >= thr) && (f2 > f1)) begin
      res = DEC_MARK;
    end
    return res;
  endfunction

endpackage

// File: rtl/fsk_bit_decoder_if.sv
// Word handshake between the decoder (master) and the capture-control logic (slave).
interface fsk_bit_decoder_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/fsk_word_assembler.sv
// Packs decided bits LSB-first into words; the last bit and its word_valid share an edge.
// Completed words wait on word_ready; a word finishing while one is still held is dropped and flagged.
module fsk_word_assembler
  import fsk_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              i_enable,
  input  logic              i_dec_vld,
  input  dec_e              i_dec,
  fsk_bit_decoder_if.master word_if,
  output logic              o_overrun
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_word_data;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_word_valid;
  logic                  r_overrun;

  logic [DATA_WIDTH-1:0] w_new_word;
  logic                  w_bit_ok;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_load;

  assign w_bit_ok = i_dec_vld && (i_dec != DEC_ERROR);
  assign w_last   = w_bit_ok && (r_cnt == LAST_IDX);
  assign w_accept = i_enable && r_word_valid && word_if.word_ready;
  assign w_load   = w_last && (!r_word_valid || word_if.word_ready);

  always_comb begin
    w_new_word        = r_shift;
    w_new_word[r_cnt] = (i_dec == DEC_MARK);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_bit_ok) begin
        r_shift <= w_new_word;
        r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
      end else if (i_dec_vld) begin
        r_cnt <= '0;
      end

      // A load on the accept edge replaces the outgoing word instead of dropping valid.
      if (w_load) begin
        r_word_data  <= w_new_word;
        r_word_valid <= 1'b1;
      end else if (w_accept) begin
        r_word_valid <= 1'b0;
      end

      if (w_last && !w_load) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign word_if.word_data  = r_word_data;
  assign word_if.word_valid = r_word_valid;
  assign o_overrun          = r_overrun;

endmodule

// File: rtl/fsk_bit_decoder.sv
// FSK bit decoder: samples analyzer tone counts once per window, pulses the analyzer clear, decides space/mark/error.
// Decision one cycle after capture; bits are never back-pressured, words wait on word_ready.
module fsk_bit_decoder
  import fsk_pkg::*;
#(
  parameter int CLOCK         = 50000000,
  parameter int BIT_RATE      = 1000,
  parameter int MIN_OCCUPANCY = 50,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [TICK_WIDTH-1:0] f1_value,
  input  logic [TICK_WIDTH-1:0] f2_value,
  output logic                  analyzer_clear,
  output logic                  bit_valid,
  output logic                  bit_value,
  output logic                  bit_error,
  fsk_bit_decoder_if.master     word_if,
  output logic                  overrun
);

  localparam int WINDOW_TICKS = calc_window_ticks(CLOCK, BIT_RATE);
  localparam int THRESHOLD    = calc_threshold(WINDOW_TICKS, MIN_OCCUPANCY);
  localparam int WC_W         = $clog2(WINDOW_TICKS);

  localparam logic [WC_W-1:0]       WC_LAST = WC_W'(WINDOW_TICKS - 1);
  localparam logic [TICK_WIDTH-1:0] THR_V   = TICK_WIDTH'(THRESHOLD);

  if (WINDOW_TICKS < 4) begin : g_bad_window
    $error("fsk_bit_decoder: WINDOW_TICKS must be at least 4");
  end

  logic [WC_W-1:0]       r_wc;
  logic [TICK_WIDTH-1:0] r_f1_q;
  logic [TICK_WIDTH-1:0] r_f2_q;
  logic                  r_pend;
  logic                  r_analyzer_clear;
  logic                  r_bit_valid;
  logic                  r_bit_value;
  logic                  r_bit_error;

  logic                  w_capture;
  logic                  w_apply;
  dec_e                  w_dec;

  assign w_capture = enable && (r_wc == WC_LAST);
  assign w_dec     = decide(r_f1_q, r_f2_q, THR_V);
  // A captured window waits for the next enabled edge before it is announced.
  assign w_apply   = r_pend && enable;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_wc             <= '0;
      r_f1_q           <= '0;
      r_f2_q           <= '0;
      r_pend           <= 1'b0;
      r_analyzer_clear <= 1'b1;
      r_bit_valid      <= 1'b0;
      r_bit_value      <= 1'b0;
      r_bit_error      <= 1'b0;
    end else begin
      r_analyzer_clear <= w_capture;
      if (enable) begin
        r_wc <= w_capture ? '0 : r_wc + WC_W'(1);
      end
      if (w_capture) begin
        r_f1_q <= f1_value;
        r_f2_q <= f2_value;
      end
      r_pend      <= w_capture || (r_pend && !enable);
      r_bit_valid <= w_apply;
      if (w_apply) begin
        r_bit_value <= (w_dec == DEC_MARK);
        r_bit_error <= (w_dec == DEC_ERROR);
      end
    end
  end

  fsk_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_assembler (
    .clock     (clock),
    .clear     (clear),
    .i_enable  (enable),
    .i_dec_vld (w_apply),
    .i_dec     (w_dec),
    .word_if   (word_if),
    .o_overrun (overrun)
  );

  assign analyzer_clear = r_analyzer_clear;
  assign bit_valid      = r_bit_valid;
  assign bit_value      = r_bit_value;
  assign bit_error      = r_bit_error;

endmodule

// File: tb/tb_fsk_bit_decoder.sv
// Bench for fsk_bit_decoder: directed scenarios with literal expectations plus randomized windows,
// all outputs compared every cycle against a window/queue level reference model.
`timescale 1ns/1ps
module tb_fsk_bit_decoder;

  localparam int W   = 100;
  localparam int THR = 50;
  localparam int DW  = 8;

  logic        clock = 1'b0;
  logic        clear;
  logic        enable;
  logic [31:0] f1_value;
  logic [31:0] f2_value;
  logic        analyzer_clear;
  logic        bit_valid;
  logic        bit_value;
  logic        bit_error;
  logic        overrun;

  fsk_bit_decoder_if #(.DATA_WIDTH(DW)) wif ();

  fsk_bit_decoder #(
    .CLOCK         (100000),
    .BIT_RATE      (1000),
    .MIN_OCCUPANCY (50),
    .DATA_WIDTH    (DW)
  ) dut (
    .clock          (clock),
    .clear          (clear),
    .enable         (enable),
    .f1_value       (f1_value),
    .f2_value       (f2_value),
    .analyzer_clear (analyzer_clear),
    .bit_valid      (bit_valid),
    .bit_value      (bit_value),
    .bit_error      (bit_error),
    .word_if        (wif),
    .overrun        (overrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;
  bit rand_ready = 1'b0;
  int phase = 0;

  // Reference model state: enabled ticks into the window, pending capture, bits of the current word.
  int          m_wc;
  bit          m_pend;
  int unsigned m_f1, m_f2;
  bit          m_aclr, m_bv, m_bval, m_berr, m_wv, m_ovr;
  logic [DW-1:0] m_wd;
  bit          m_bits[$];

  task automatic model_step();
    bit wv_before;
    bit loaded;
    int kind;
    logic [DW-1:0] w;
    if (clear) begin
      m_wc = 0; m_pend = 0; m_aclr = 1; m_bv = 0; m_bval = 0; m_berr = 0;
      m_wv = 0; m_ovr = 0; m_wd = '0; m_bits.delete();
      return;
    end
    wv_before = m_wv;
    loaded = 0;
    m_bv = 0;
    if (m_pend && enable) begin
      m_pend = 0;
      m_bv = 1;
      if (m_f1 >= THR && m_f1 > m_f2) kind = 0;
      else if (m_f2 >= THR && m_f2 > m_f1) kind = 1;
      else kind = 2;
      m_bval = (kind == 1);
      m_berr = (kind == 2);
      if (kind == 2) begin
        m_bits.delete();
      end else begin
        m_bits.push_back(kind == 1);
        if (m_bits.size() == DW) begin
          for (int i = 0; i < DW; i++) w[i] = m_bits[i];
          m_bits.delete();
          if (!wv_before || wif.word_ready) begin
            m_wd = w; m_wv = 1; loaded = 1;
          end else begin
            m_ovr = 1;
          end
        end
      end
    end
    if (enable && wv_before && wif.word_ready && !loaded) m_wv = 0;
    m_aclr = 0;
    if (enable) begin
      m_wc++;
      if (m_wc == W) begin
        m_wc = 0; m_f1 = f1_value; m_f2 = f2_value; m_aclr = 1; m_pend = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (checking) begin
      n_checks++;
      if ({analyzer_clear, bit_valid, bit_value, bit_error, wif.word_valid, overrun} !==
          {m_aclr, m_bv, m_bval, m_berr, m_wv, m_ovr} || wif.word_data !== m_wd) begin
        n_errors++;
        $display("FAIL cycle_compare t=%0t actual aclr,bv,bval,berr,wv,ovr=%b%b%b%b%b%b data=%h required %b%b%b%b%b%b data=%h",
                 $time, analyzer_clear, bit_valid, bit_value, bit_error, wif.word_valid, overrun, wif.word_data,
                 m_aclr, m_bv, m_bval, m_berr, m_wv, m_ovr, m_wd);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (clear) phase = 0;
    else if (enable) phase = (phase + 1) % W;
    #1;
    if (rand_ready) wif.word_ready = ($urandom_range(0, 3) == 0);
  endtask

  // Runs to the capture edge; returns ticks spent and bit_valid/analyzer_clear hits seen while disabled.
  task automatic window(input int f1, input int f2, input int gap_at, input int gap_len,
                        output int n, output int gap_hits);
    int gl;
    gl = gap_len;
    n = 0;
    gap_hits = 0;
    f1_value = f1;
    f2_value = f2;
    do begin
      if (gl > 0 && phase == gap_at) begin
        enable = 1'b0;
        for (int g = 0; g < gl; g++) begin
          tick();
          n++;
          if (bit_valid || analyzer_clear) gap_hits++;
        end
        enable = 1'b1;
        gl = 0;
      end
      tick();
      n++;
    end while (phase != 0 && n < 1000);
  endtask

  // Sends one window and stops in the cycle where its decision is visible.
  task automatic send_bit(input int f1, input int f2, input int gap_at, input int gap_len, input bit ready_last);
    int n, gh, p0;
    p0 = phase;
    window(f1, f2, gap_at, gap_len, n, gh);
    check("window_len", n, W - p0 + gap_len);
    if (gap_len > 0) check("gap_quiet", gh, 0);
    if (ready_last) wif.word_ready = 1'b1;
    tick();
    if (ready_last) wif.word_ready = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] pat, input bit ready_last);
    for (int i = 0; i < 8; i++) begin
      if (pat[i]) send_bit(10, 75, 0, 0, ready_last && (i == 7));
      else        send_bit(75, 10, 0, 0, ready_last && (i == 7));
    end
  endtask

  initial begin
    int n, gh, kind, f1, f2, ga, gl;
    logic [7:0] pat;
    clear = 1'b1; enable = 1'b1; f1_value = '0; f2_value = '0; wif.word_ready = 1'b0;

    // Reset
    tick(); checking = 1'b1; tick(); tick();
    check("reset_aclr", 32'(analyzer_clear), 1);
    check("reset_outs", 32'({bit_valid, bit_value, bit_error, wif.word_valid, overrun}), 0);
    check("reset_data", 32'(wif.word_data), 0);
    clear = 1'b0;
    tick();
    check("aclr_after_release", 32'(analyzer_clear), 0);
    window(70, 10, 0, 0, n, gh);
    check("first_pulse_cycle", n + 1, 100);
    check("first_pulse", 32'(analyzer_clear), 1);
    tick();
    check("space_bit", 32'({bit_valid, bit_value, bit_error}), 4);
    tick();
    check("bit_valid_one_cycle", 32'(bit_valid), 0);
    check("aclr_one_cycle", 32'(analyzer_clear), 0);

    // Two more good bits, then an error discards the partial word
    send_bit(20, 80, 0, 0, 1'b0);
    check("mark_bit", 32'({bit_valid, bit_value, bit_error}), 6);
    send_bit(60, 5, 0, 0, 1'b0);
    send_bit(20, 30, 0, 0, 1'b0);
    check("error_bit", 32'({bit_valid, bit_value, bit_error}), 5);

    // Word 0x4D, completes only on its eighth bit
    pat = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      if (pat[i]) send_bit(10, 75, 0, 0, 1'b0);
      else        send_bit(75, 10, 0, 0, 1'b0);
      check("word_valid_timing", 32'(wif.word_valid), (i == 7) ? 1 : 0);
    end
    check("word_with_last_bit", 32'({bit_valid, bit_value, bit_error}), 4);
    check("word_data", 32'(wif.word_data), 32'h4D);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("word_hold", 32'({wif.word_valid, wif.word_data}), 32'h14D);
    end
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
    check("word_accept_drop", 32'(wif.word_valid), 0);

    // Overrun: second word completes while the first is still held
    send_word(8'h4D, 1'b0);
    check("second_load", 32'({wif.word_valid, wif.word_data}), 32'h14D);
    send_word(8'hA5, 1'b0);
    check("overrun_set", 32'(overrun), 1);
    check("overrun_keeps_old", 32'(wif.word_data), 32'h4D);
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;

    // Mid-window reset, then completion on an accepting cycle
    clear = 1'b1; tick(); tick();
    check("overrun_cleared", 32'({overrun, wif.word_valid, analyzer_clear}), 1);
    clear = 1'b0;
    send_word(8'h11, 1'b0);
    check("word_11", 32'({wif.word_valid, wif.word_data}), 32'h111);
    send_word(8'h3C, 1'b1);
    check("load_on_accept", 32'({wif.word_valid, wif.word_data}), 32'h13C);
    check("no_overrun", 32'(overrun), 0);

    // Enable gap of 30 cycles pushes the capture to cycle 130
    clear = 1'b1; tick();
    clear = 1'b0;
    window(70, 10, 40, 30, n, gh);
    check("gap_capture_cycle", n, 130);
    check("gap_no_bits", gh, 0);
    check("gap_pulse", 32'(analyzer_clear), 1);
    tick();
    check("gap_bit", 32'({bit_valid, bit_value, bit_error}), 4);

    // Threshold and tie boundaries
    send_bit(50, 49, 0, 0, 1'b0);
    check("thr_space", 32'({bit_valid, bit_value, bit_error}), 4);
    send_bit(49, 10, 0, 0, 1'b0);
    check("below_thr", 32'({bit_valid, bit_value, bit_error}), 5);
    send_bit(70, 70, 0, 0, 1'b0);
    check("tie", 32'({bit_valid, bit_value, bit_error}), 5);
    send_bit(49, 50, 0, 0, 1'b0);
    check("thr_mark", 32'({bit_valid, bit_value, bit_error}), 6);

    // Randomized windows, gaps and consumer readiness
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        f1 = $urandom_range(THR, 100); f2 = $urandom_range(0, f1 - 1);
      end else if (kind < 8) begin
        f2 = $urandom_range(THR, 100); f1 = $urandom_range(0, f2 - 1);
      end else begin
        f1 = $urandom_range(0, 60); f2 = $urandom_range(0, 60);
      end
      ga = 0; gl = 0;
      if ($urandom_range(0, 3) == 0) begin
        ga = $urandom_range(10, 80); gl = $urandom_range(1, 20);
      end
      send_bit(f1, f2, ga, gl, 1'b0);
    end
    rand_ready = 1'b0;
    wif.word_ready = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
